// File: rtl/display_field_controller.sv
// display_field_controller
// Turns FIELDS packed 7-bit binary fields into two decimal digits each.
// Supports a 12/24-hour hour field, per-field blinking from an internal
// timer that restarts when editing starts, and seven-segment patterns for
// every digit. Every output is registered, with one cycle of latency.
module display_field_controller #(
   parameter int FIELDS         = 3,
   parameter int BLINK_HALF     = 25_000_000,
   parameter int HOUR_FIELD_12H = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [FIELDS-1:0]       flash,
   input  logic                    display_mode,
   input  logic [7*FIELDS-1:0]     in_value,
   output logic [8*FIELDS-1:0]     digit_code,
   output logic [14*FIELDS-1:0]    seg_out,
   output logic                    blink_phase
);

   localparam int unsigned NF       = FIELDS;
   localparam int          CW       = $clog2(BLINK_HALF);
   localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_HALF - 1);

   localparam logic [3:0] CODE_A     = 4'd10;
   localparam logic [3:0] CODE_P     = 4'd11;
   localparam logic [3:0] CODE_BLANK = 4'd15;
   localparam logic [6:0] SEG_BLANK  = 7'h00;

   // Seven-segment decoder, segments {g,f,e,d,c,b,a}, active high.
   function automatic logic [6:0] segment(input logic [3:0] code);
      logic [6:0] s;
      case (code)
         4'd0:    s = 7'h3F;
         4'd1:    s = 7'h06;
         4'd2:    s = 7'h5B;
         4'd3:    s = 7'h4F;
         4'd4:    s = 7'h66;
         4'd5:    s = 7'h6D;
         4'd6:    s = 7'h7D;
         4'd7:    s = 7'h07;
         4'd8:    s = 7'h7F;
         4'd9:    s = 7'h6F;
         4'd10:   s = 7'h77;   // A
         4'd11:   s = 7'h73;   // P
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

   // Saturate at 99, then split into {tens, units} digit codes.
   function automatic logic [7:0] bcd_pair(input logic [6:0] v);
      logic [6:0] s;
      logic [3:0] hi;
      logic [3:0] lo;
      s  = (v > 7'd99) ? 7'd99 : v;
      hi = 4'(s / 7'd10);
      lo = 4'(s % 7'd10);
      return {hi, lo};
   endfunction

   logic [CW-1:0]       cnt;
   logic [CW-1:0]       cnt_next;
   logic                phase_next;
   logic [FIELDS-1:0]   flash_q;
   logic [FIELDS-1:0]   flash_rise;

   logic                mode12;
   logic [6:0]          hour_raw;
   logic [6:0]          hour_sat;
   logic [6:0]          hour12;
   logic                is_pm;
   logic [8*FIELDS-1:0] pair_code;
   logic [FIELDS-1:0]   pair_flash;
   logic [8*FIELDS-1:0] code_next;
   logic [14*FIELDS-1:0] seg_next;

   assign flash_rise = flash & ~flash_q;

   // Blink timer next state: a new flash bit restarts the visible half-period,
   // and that restart takes priority over the normal wrap.
   always_comb begin
      cnt_next   = cnt + CW'(1);
      phase_next = blink_phase;
      if (|flash_rise) begin
         cnt_next   = '0;
         phase_next = 1'b0;
      end else if (cnt == CNT_LAST) begin
         cnt_next   = '0;
         phase_next = ~blink_phase;
      end
   end

   // Blink timer and flash history registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt         <= '0;
         blink_phase <= 1'b0;
         flash_q     <= '0;
      end else begin
         cnt         <= cnt_next;
         blink_phase <= phase_next;
         flash_q     <= flash;
      end
   end

   // 12-hour conversion of the most significant field.
   always_comb begin
      mode12   = (HOUR_FIELD_12H != 0) && display_mode;
      hour_raw = in_value[7*(NF-1) +: 7];
      hour_sat = (hour_raw > 7'd23) ? 7'd23 : hour_raw;
      is_pm    = (hour_sat >= 7'd12);
      if (hour_sat == 7'd0)
         hour12 = 7'd12;
      else if (hour_sat > 7'd12)
         hour12 = hour_sat - 7'd12;
      else
         hour12 = hour_sat;
   end

   // Pair formatting. In 12-hour mode every field shifts down one pair to make
   // room for the A/P indicator, and the flash bit follows the displayed pair.
   always_comb begin
      pair_code  = '1;
      pair_flash = '0;
      for (int unsigned p = 0; p < NF; p++) begin
         pair_code[8*p +: 8] = bcd_pair(in_value[7*p +: 7]);
         pair_flash[p]       = flash[p];
      end
      if (mode12) begin
         pair_code[8*(NF-1) +: 8] = {(is_pm ? CODE_P : CODE_A), CODE_BLANK};
         pair_flash[NF-1]         = flash[NF-1];
         pair_code[8*(NF-2) +: 8] = bcd_pair(hour12);
         pair_flash[NF-2]         = flash[NF-1];
         for (int unsigned p = 0; p + 2 < NF; p++) begin
            pair_code[8*p +: 8] = bcd_pair(in_value[7*(p+1) +: 7]);
            pair_flash[p]       = flash[p+1];
         end
      end
   end

   // Blanking uses the phase that is being registered alongside the codes, so
   // the digits and blink_phase always agree on the same cycle.
   always_comb begin
      code_next = '1;
      seg_next  = '0;
      for (int unsigned p = 0; p < NF; p++) begin
         if (phase_next && pair_flash[p])
            code_next[8*p +: 8] = {CODE_BLANK, CODE_BLANK};
         else
            code_next[8*p +: 8] = pair_code[8*p +: 8];
      end
      for (int unsigned d = 0; d < 2*NF; d++) begin
         seg_next[7*d +: 7] = segment(code_next[4*d +: 4]);
      end
   end

   // Output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         digit_code <= '1;
         seg_out    <= {(2*FIELDS){SEG_BLANK}};
      end else begin
         digit_code <= code_next;
         seg_out    <= seg_next;
      end
   end

endmodule

// File: tb/tb_display_field_controller.sv
// Scoreboard bench for display_field_controller (FIELDS=3, BLINK_HALF=4).
module tb_display_field_controller;

   localparam int FIELDS = 3;
   localparam int BH     = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  flash;
   logic        display_mode;
   logic [20:0] in_value;
   logic [23:0] digit_code;
   logic [41:0] seg_out;
   logic        blink_phase;

   always #5 clk = ~clk;

   display_field_controller #(
      .FIELDS         (FIELDS),
      .BLINK_HALF     (BH),
      .HOUR_FIELD_12H (1)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .flash        (flash),
      .display_mode (display_mode),
      .in_value     (in_value),
      .digit_code   (digit_code),
      .seg_out      (seg_out),
      .blink_phase  (blink_phase)
   );

   typedef struct {
      logic [23:0] code;
      logic [41:0] seg;
      logic        ph;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // Reference blink timer state (mirrors what the DUT should hold now).
   int       m_cnt = 0;
   logic     m_ph  = 1'b0;
   logic [2:0] m_fq = 3'b000;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [6:0] seg_of(input logic [3:0] c);
      case (c)
         4'd0:  return 7'b0111111;
         4'd1:  return 7'b0000110;
         4'd2:  return 7'b1011011;
         4'd3:  return 7'b1001111;
         4'd4:  return 7'b1100110;
         4'd5:  return 7'b1101101;
         4'd6:  return 7'b1111101;
         4'd7:  return 7'b0000111;
         4'd8:  return 7'b1111111;
         4'd9:  return 7'b1101111;
         4'd10: return 7'b1110111;
         4'd11: return 7'b1110011;
         default: return 7'b0000000;
      endcase
   endfunction

   function automatic logic [41:0] segs(input logic [23:0] c);
      logic [41:0] s;
      s = '0;
      for (int d = 0; d < 6; d++) s[7*d +: 7] = seg_of(c[4*d +: 4]);
      return s;
   endfunction

   function automatic logic [7:0] two_dig(input int v);
      int s;
      logic [3:0] h;
      logic [3:0] l;
      s = (v > 99) ? 99 : v;
      h = 4'(s / 10);
      l = 4'(s % 10);
      return {h, l};
   endfunction

   function automatic logic [20:0] v3(input int h, input int m, input int s);
      return {7'(h), 7'(m), 7'(s)};
   endfunction

   function automatic logic [23:0] fmt(input logic [20:0] val, input logic md,
                                       input logic [2:0] fl, input logic ph);
      int f0, f1, f2, h, h12;
      logic [7:0] p2, p1, p0;
      logic b2, b1, b0;
      logic [3:0] ap;
      f0 = int'(val[6:0]);
      f1 = int'(val[13:7]);
      f2 = int'(val[20:14]);
      if (!md) begin
         p2 = two_dig(f2); p1 = two_dig(f1); p0 = two_dig(f0);
         b2 = fl[2]; b1 = fl[1]; b0 = fl[0];
      end else begin
         h   = (f2 > 23) ? 23 : f2;
         ap  = (h >= 12) ? 4'd11 : 4'd10;
         h12 = h % 12;
         if (h12 == 0) h12 = 12;
         p2 = {ap, 4'hF}; p1 = two_dig(h12); p0 = two_dig(f1);
         b2 = fl[2]; b1 = fl[2]; b0 = fl[1];
      end
      if (ph && b2) p2 = 8'hFF;
      if (ph && b1) p1 = 8'hFF;
      if (ph && b0) p0 = 8'hFF;
      return {p2, p1, p0};
   endfunction

   // Drive one cycle, push the expectation, then compare after the edge.
   task automatic step(input logic rst, input logic [2:0] fl, input logic md,
                       input logic [20:0] val, input string tag);
      exp_t e;
      exp_t got;
      @(negedge clk);
      reset = rst; flash = fl; display_mode = md; in_value = val;
      if (rst) begin
         m_cnt = 0; m_ph = 1'b0; m_fq = 3'b000;
         e.code = 24'hFFFFFF;
      end else begin
         if ((fl & ~m_fq) != 3'b000) begin
            m_cnt = 0; m_ph = 1'b0;
         end else if (m_cnt == BH - 1) begin
            m_cnt = 0; m_ph = ~m_ph;
         end else begin
            m_cnt++;
         end
         m_fq   = fl;
         e.code = fmt(val, md, fl, m_ph);
      end
      e.ph  = m_ph;
      e.seg = segs(e.code);
      sb.push_back(e);
      @(posedge clk);
      #1;
      got = sb.pop_front();
      check({tag, " code"},  64'(digit_code),  64'(got.code));
      check({tag, " seg"},   64'(seg_out),     64'(got.seg));
      check({tag, " phase"}, 64'(blink_phase), 64'(got.ph));
   endtask

   int hours[5] = '{0, 11, 12, 13, 23};
   bit found;

   initial begin
      reset = 1'b1; flash = 3'b000; display_mode = 1'b0; in_value = '0;

      step(1'b1, 3'b000, 1'b0, v3(13, 5, 59), "reset0");
      step(1'b1, 3'b000, 1'b0, v3(13, 5, 59), "reset1");
      check("reset literal", 64'(digit_code), 64'h00FFFFFF);

      step(1'b0, 3'b000, 1'b0, v3(13, 5, 59), "dec24");
      check("dec24 literal", 64'(digit_code), 64'h130559);
      step(1'b0, 3'b000, 1'b0, v3(7, 42, 0), "dec24b");

      foreach (hours[i]) step(1'b0, 3'b000, 1'b1, v3(hours[i], 7, 30), "h12");
      step(1'b0, 3'b000, 1'b1, v3(0, 7, 30), "h12zero");
      check("h12zero literal", 64'(digit_code), 64'hAF1207);

      step(1'b0, 3'b000, 1'b0, v3(0, 0, 127), "sat99");
      check("sat99 literal", 64'(digit_code[7:0]), 64'h99);
      step(1'b0, 3'b000, 1'b1, v3(100, 7, 0), "sat23");
      check("sat23 literal", 64'(digit_code), 64'hBF1107);

      // Minute pair blinking in 24-hour mode.
      for (int i = 0; i < 12; i++) step(1'b0, 3'b010, 1'b0, v3(13, 5, 59), "blink24");

      // Restart: raise flash[2] while blanked at cnt=2.
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (m_ph && m_cnt == 2) found = 1'b1;
         else step(1'b0, 3'b010, 1'b0, v3(13, 5, 59), "prerestart");
      end
      check("restart wait", 64'(found), 64'd1);
      step(1'b0, 3'b110, 1'b0, v3(13, 5, 59), "restart");
      check("restart phase literal", 64'(blink_phase), 64'd0);
      for (int i = 0; i < 9; i++) step(1'b0, 3'b110, 1'b0, v3(13, 5, 59), "postrestart");

      // 12-hour blinking: hour + A/P together, then field 0 (no visible effect).
      for (int i = 0; i < 9; i++) step(1'b0, 3'b100, 1'b1, v3(15, 33, 8), "blink12h");
      for (int i = 0; i < 6; i++) step(1'b0, 3'b001, 1'b1, v3(15, 33, 8), "blink12s");

      // Mode toggling while blinking must not disturb the timer.
      for (int i = 0; i < 8; i++) step(1'b0, 3'b011, 1'(i % 2), v3(21, 9, 44), "modetog");

      // Reset during a blank phase with all fields flashing.
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (m_ph) found = 1'b1;
         else step(1'b0, 3'b111, 1'b0, v3(9, 15, 26), "prereset");
      end
      check("reset wait", 64'(found), 64'd1);
      step(1'b1, 3'b111, 1'b0, v3(9, 15, 26), "midreset");
      for (int i = 0; i < 9; i++) step(1'b0, 3'b111, 1'b0, v3(9, 15, 26), "postreset");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
